fifo_word_reader: RTL and testbench

Clocked reader for the trigger-driven word FIFO. It pulls words out of the FIFO by pulsing trigger_read and presents each word with a valid/accept handshake to a word consumer such as the word-to-block assembler. It also counts words into bursts of BURST words (one block's worth) and flags each completed burst.

---
 rtl/fifo_word_reader.sv | 132 +++++++++++++
 tb/tb_fifo_word_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_reader
// Description : Pulls words from a trigger-driven word FIFO with a one-clock
//               read strobe, presents each word to a consumer through a
//               valid/accept handshake, counts transfers and flags every
//               completed burst of BURST words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_reader #(
  parameter int WSIZE = 32,  // word width, matches the FIFO
  parameter int BURST = 4,   // words per burst, power of two >= 2
  parameter int CNTW  = 16   // width of the words_read statistic
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WSIZE-1:0] fifo_read_data,
  output logic             trigger_read,
  output logic [WSIZE-1:0] word_out,
  output logic             word_ready,
  input  logic             pull_word,
  output logic             burst_done,
  output logic [CNTW-1:0]  words_read
);

  // Burst position counter width; BURST is a power of two so the counter
  // wraps modulo BURST by plain binary overflow.
  localparam int c_bcnt_w = (BURST > 2) ? $clog2(BURST) : 1;
  localparam logic [c_bcnt_w-1:0] c_bcnt_last = c_bcnt_w'(BURST - 1);

  // Reader states
  localparam logic [1:0] c_st_idle    = 2'd0;  // waiting for enable and data
  localparam logic [1:0] c_st_req     = 2'd1;  // strobe the FIFO this cycle
  localparam logic [1:0] c_st_wait    = 2'd2;  // let FIFO read_data settle
  localparam logic [1:0] c_st_present = 2'd3;  // word offered to consumer

  logic [1:0]          state_q,        state_d;
  logic                trigger_read_q, trigger_read_d;
  logic [WSIZE-1:0]    word_out_q,     word_out_d;
  logic                word_ready_q,   word_ready_d;
  logic [c_bcnt_w-1:0] bcnt_q,         bcnt_d;
  logic                burst_done_q,   burst_done_d;
  logic [CNTW-1:0]     words_read_q,   words_read_d;

  // A transfer happens only when the consumer accepts a presented word.
  logic xfer;
  assign xfer = word_ready_q & pull_word;

  // Next-state and datapath logic; the strobe is decided one cycle ahead so
  // trigger_read comes straight from a flop and is high only in REQ.
  always_comb begin
    state_d        = state_q;
    trigger_read_d = 1'b0;
    word_out_d     = word_out_q;
    word_ready_d   = word_ready_q;
    bcnt_d         = bcnt_q;
    burst_done_d   = 1'b0;
    words_read_d   = words_read_q;

    case (state_q)
      c_st_idle: begin
        if (enable && !fifo_empty) begin
          state_d        = c_st_req;
          trigger_read_d = 1'b1;
        end
      end

      // fifo_empty and enable are deliberately ignored while a read is in
      // flight; the strobed word is always carried through to PRESENT.
      c_st_req: begin
        state_d = c_st_wait;
      end

      c_st_wait: begin
        word_out_d   = fifo_read_data;
        word_ready_d = 1'b1;
        state_d      = c_st_present;
      end

      c_st_present: begin
        if (xfer) begin
          words_read_d = words_read_q + 1'b1;
          bcnt_d       = bcnt_q + 1'b1;
          burst_done_d = (bcnt_q == c_bcnt_last);
          word_ready_d = 1'b0;
          if (enable && !fifo_empty) begin
            state_d        = c_st_req;
            trigger_read_d = 1'b1;
          end else begin
            state_d = c_st_idle;
          end
        end
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // State and output registers; reset discards any pending word and clears
  // the statistics immediately, without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= c_st_idle;
      trigger_read_q <= 1'b0;
      word_out_q     <= '0;
      word_ready_q   <= 1'b0;
      bcnt_q         <= '0;
      burst_done_q   <= 1'b0;
      words_read_q   <= '0;
    end else begin
      state_q        <= state_d;
      trigger_read_q <= trigger_read_d;
      word_out_q     <= word_out_d;
      word_ready_q   <= word_ready_d;
      bcnt_q         <= bcnt_d;
      burst_done_q   <= burst_done_d;
      words_read_q   <= words_read_d;
    end
  end

  assign trigger_read = trigger_read_q;
  assign word_out     = word_out_q;
  assign word_ready   = word_ready_q;
  assign burst_done   = burst_done_q;
  assign words_read   = words_read_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_word_reader
// Description : Self-checking bench for fifo_word_reader. A queue models the
//               FIFO, a scoreboard holds the words the reader has strobed out
//               of it, and a negedge monitor checks delivery order, counters,
//               burst pulses, strobe spacing, latency and word stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_reader;
  localparam int WSIZE = 32;
  localparam int BURST = 4;
  localparam int CNTW  = 4;

  logic             clock      = 1'b0;
  logic             reset_n    = 1'b0;
  logic             enable     = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             pull_word  = 1'b0;
  logic [WSIZE-1:0] fifo_read_data = '0;
  logic             trigger_read;
  logic             word_ready;
  logic             burst_done;
  logic [WSIZE-1:0] word_out;
  logic [CNTW-1:0]  words_read;

  int vectors     = 0;
  int miscompares = 0;

  logic [WSIZE-1:0] fifo_q[$];   // contents of the modelled FIFO
  logic [WSIZE-1:0] exp_q[$];    // words strobed out, awaiting delivery

  int n_trig  = 0;
  int n_xfer  = 0;
  int n_burst = 0;

  // reference model state (monitor only)
  int               m_count = 0;
  int               m_burst = 0;
  logic             m_done  = 1'b0;
  logic             trig_d1 = 1'b0;
  logic             trig_d2 = 1'b0;
  logic             prev_ready = 1'b0;
  logic [WSIZE-1:0] prev_word  = '0;
  logic [WSIZE-1:0] popped     = '0;
  int               gap = 3;

  fifo_word_reader #(.WSIZE(WSIZE), .BURST(BURST), .CNTW(CNTW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .trigger_read   (trigger_read),
    .word_out       (word_out),
    .word_ready     (word_ready),
    .pull_word      (pull_word),
    .burst_done     (burst_done),
    .words_read     (words_read)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [WSIZE-1:0] v);
    fifo_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int k = 0;
    while (word_ready !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk(name, {63'd0, word_ready}, 64'd1);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int k = 0;
    while (n_xfer < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, {63'd0, (n_xfer >= target)}, 64'd1);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: FIFO model, scoreboard and reference counters, all at negedge.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("reset_ready",   {63'd0, word_ready},   64'd0);
      chk("reset_trigger", {63'd0, trigger_read}, 64'd0);
      chk("reset_done",    {63'd0, burst_done},   64'd0);
      chk("reset_count",   64'(words_read),       64'd0);
      chk("reset_word",    64'(word_out),         64'd0);
      m_count = 0; m_burst = 0; m_done = 1'b0;
      trig_d1 = 1'b0; trig_d2 = 1'b0; prev_ready = 1'b0; gap = 3;
      exp_q.delete();
      fifo_q.delete();
      fifo_empty = 1'b1;
    end else begin
      chk("words_read", 64'(words_read), 64'(m_count));
      chk("burst_done", {63'd0, burst_done}, {63'd0, m_done});
      if (burst_done) n_burst++;
      // a word appears exactly two cycles after its read strobe
      chk("ready_latency", {63'd0, (word_ready && !prev_ready)}, {63'd0, trig_d2});
      if (prev_ready && word_ready)
        chk("word_stable", 64'(word_out), 64'(prev_word));
      if (trigger_read) begin
        n_trig++;
        chk("trigger_gap", {63'd0, (gap >= 3)}, 64'd1);
        chk("trigger_nonempty", {63'd0, (fifo_q.size() > 0)}, 64'd1);
        gap = 0;
        if (fifo_q.size() > 0) begin
          popped = fifo_q.pop_front();
          fifo_read_data = popped;
          exp_q.push_back(popped);
        end
        fifo_empty = (fifo_q.size() == 0);
      end
      if (word_ready && pull_word) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", 64'd1, 64'd0);
        end else begin
          popped = exp_q.pop_front();
          chk("word_out", 64'(word_out), 64'(popped));
        end
        m_done  = (m_burst == BURST - 1);
        m_burst = (m_burst + 1) % BURST;
        m_count = (m_count + 1) % (1 << CNTW);
      end else begin
        m_done = 1'b0;
      end
      trig_d2    = trig_d1;
      trig_d1    = trigger_read;
      prev_ready = word_ready;
      prev_word  = word_out;
      if (gap < 1000) gap++;
    end
  end

  initial begin
    int b_trig, b_xfer, b_burst;

    // Idle with an empty FIFO: nothing must happen.
    repeat (3) tick();
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();
    b_trig = n_trig;
    repeat (10) tick();
    chk("empty_no_trigger", 64'(n_trig - b_trig), 64'd0);
    chk("empty_ready", {63'd0, word_ready}, 64'd0);
    chk("empty_count", 64'(words_read), 64'd0);

    // Four preloaded words streamed with pull_word held high.
    b_trig = n_trig; b_xfer = n_xfer; b_burst = n_burst;
    pull_word = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    wait_xfers(b_xfer + 4, 40, "stream_timeout");
    repeat (2) tick();
    chk("stream_triggers", 64'(n_trig - b_trig), 64'd4);
    chk("stream_bursts", 64'(n_burst - b_burst), 64'd1);
    chk("stream_count", 64'(words_read), 64'd4);

    // Consumer stalls on a single word.
    pull_word = 1'b0;
    b_trig = n_trig;
    push(32'h55);
    wait_ready(10, "stall_ready_timeout");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stall_ready", {63'd0, word_ready}, 64'd1);
      chk("stall_word", 64'(word_out), 64'h55);
    end
    chk("stall_triggers", 64'(n_trig - b_trig), 64'd1);
    pull_word = 1'b1;
    tick();
    chk("stall_release_ready", {63'd0, word_ready}, 64'd0);
    chk("stall_release_count", 64'(words_read), 64'd5);
    pull_word = 1'b0;
    tick();
    chk("stall_idle_trigger", {63'd0, trigger_read}, 64'd0);

    // enable dropped during the REQ cycle: only the in-flight word arrives.
    b_trig = n_trig; b_xfer = n_xfer;
    pull_word = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h100 + i);
    for (int k = 0; k < 10 && trigger_read !== 1'b1; k++) tick();
    chk("req_seen", {63'd0, trigger_read}, 64'd1);
    enable = 1'b0;
    repeat (10) tick();
    chk("drop_en_xfers", 64'(n_xfer - b_xfer), 64'd1);
    chk("drop_en_triggers", 64'(n_trig - b_trig), 64'd1);
    chk("drop_en_fifo_left", 64'(fifo_q.size()), 64'd2);
    fifo_q.delete();
    fifo_empty = 1'b1;
    enable = 1'b1;

    // Reset while a word is presented, after six transfers.
    reset_pulse();
    pull_word = 1'b0;
    for (int i = 0; i < 7; i++) push(32'h200 + i);
    for (int i = 0; i < 6; i++) begin
      wait_ready(10, "pre_reset_ready_timeout");
      pull_word = 1'b1;
      tick();
      pull_word = 1'b0;
    end
    chk("pre_reset_count", 64'(words_read), 64'd6);
    wait_ready(10, "pre_reset_present_timeout");
    reset_n = 1'b0;
    #2;
    chk("async_ready", {63'd0, word_ready}, 64'd0);
    chk("async_count", 64'(words_read), 64'd0);
    chk("async_done", {63'd0, burst_done}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    b_xfer = n_xfer; b_burst = n_burst;
    pull_word = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h300 + i);
    wait_xfers(b_xfer + 4, 40, "post_reset_timeout");
    repeat (2) tick();
    chk("post_reset_bursts", 64'(n_burst - b_burst), 64'd1);
    chk("post_reset_count", 64'(words_read), 64'd4);

    // Counter wrap with a 4-bit statistic: 17 transfers.
    reset_pulse();
    b_xfer = n_xfer; b_burst = n_burst;
    for (int i = 0; i < 17; i++) push(32'h400 + i);
    wait_xfers(b_xfer + 17, 80, "wrap_timeout");
    repeat (2) tick();
    chk("wrap_count", 64'(words_read), 64'd1);
    chk("wrap_bursts", 64'(n_burst - b_burst), 64'd4);

    // Randomized traffic, enable and back-pressure with occasional resets.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end else begin
        if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) push($urandom);
        enable    = ($urandom_range(0, 7) != 0);
        pull_word = ($urandom_range(0, 2) != 0);
        tick();
      end
    end

    // Drain: everything strobed or queued must be delivered.
    enable = 1'b1;
    pull_word = 1'b1;
    repeat (40) tick();
    chk("drain_fifo", 64'(fifo_q.size()), 64'd0);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
